// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b, one bit per clock, LSB first.
// Handshake: start accepted in IDLE, busy through RUN/DONE, done pulses for one cycle.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             zero
);

  // state | meaning
  // IDLE  | waiting for start; result outputs hold
  // RUN   | one difference bit per cycle, WIDTH cycles
  // DONE  | result registered, done pulse, back to IDLE next edge
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             bw;
  logic             d;
  logic             bo;

  always_comb begin
    d       = sa[0] ^ sb[0] ^ bw;
    bo      = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & bw);
    // New bit enters at the MSB; the whole register moves right one place.
    sr_next = WIDTH'({d, sr} >> 1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      sa     <= '0;
      sb     <= '0;
      sr     <= '0;
      bw     <= 1'b0;
      diff   <= '0;
      borrow <= 1'b0;
      zero   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sa    <= a;
            sb    <= b;
            bw    <= 1'b0;
            count <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sa    <= sa >> 1;
          sb    <= sb >> 1;
          sr    <= sr_next;
          bw    <= bo;
          count <= count + 1'b1;
          if (count == LAST) begin
            state  <= DONE;
            diff   <= sr_next;
            borrow <= bo;
            zero   <= (sr_next == '0);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN) || (state == DONE);
  assign done = (state == DONE);

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial unsigned subtractor computing `a - b`, one bit per clock, LSB first, with a start/busy/done handshake.
- It is the inverse-direction counterpart to the team's adder cells. The per-bit datapath is a full-subtractor cell:
  - difference bit = a_i ^ b_i ^ bin
  - borrow out = (~a_i & b_i) | (~(a_i ^ b_i) & bin)
- It serves as the area-cheap subtract path for arithmetic blocks where latency is acceptable.

Parameters:
WIDTH, 8, operand and result width in bits (legal range 1..32)

Ports:
clk  input  1  clock; all state changes on rising edge
rst  input  1  synchronous reset, active-high; sampled on rising edge of clk
start  input  1  request; accepted only when state is IDLE
a  input  WIDTH  minuend; sampled on the accepting edge only
b  input  WIDTH  subtrahend; sampled on the accepting edge only
busy  output  1  high in RUN and DONE states
done  output  1  one-cycle pulse, high only in the DONE state
diff  output  WIDTH  result (a - b) mod 2^WIDTH; holds last completed result
borrow  output  1  final borrow; 1 iff a < b unsigned; holds with diff
zero  output  1  1 iff the last completed diff == 0

Behaviour:
- Reset: one clock and reset, reset synchronous active-high.
  - rst=1 at an edge forces state=IDLE and count=0.
  - Internal shift registers and borrow register are cleared.
  - busy=0, done=0, diff=0, borrow=0, zero=1.
  - rst has priority over every other input. rst asserted mid-RUN aborts the operation with no done pulse and outputs go to their reset values.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - On an edge with start=1: latch a into sa and b into sb; clear working borrow bw=0 and count=0; go to RUN.
  - start=0: stay in IDLE; outputs hold.
- RUN, each edge:
  - Bit computation from sa[0], sb[0], bw: d, bo.
  - sa and sb shift right by 1. Shift d into the MSB of result shift register sr; sr shifts right.
  - bw <= bo; count <= count+1.
  - When count == WIDTH-1 at the edge, that is the final bit: go to DONE and register diff <= final sr value (including this bit), borrow <= bo, zero <= (final sr value == 0).
  - RUN lasts exactly WIDTH cycles.
- DONE: done=1 for exactly one cycle. On the next edge go to IDLE unconditionally.
- start handling outside IDLE: start in RUN or DONE is ignored, with no queuing. a and b changes after acceptance have no effect.
- Latency:
  - done is high in cycle WIDTH+1 after the accepting edge; for WIDTH=8, done is high 9 cycles after start is sampled.
  - The earliest next accept is the edge ending the first IDLE cycle after DONE.
  - Throughput is one result per WIDTH+2 cycles.
- Output timing: diff, borrow and zero change only on the edge entering DONE. They are stable from that point until the next DONE entry or reset.
- Width rules:
  - Result is modulo 2^WIDTH; no sign interpretation, no overflow flag.
  - WIDTH=1 degenerates to RUN lasting 1 cycle.
  - count width is clog2(WIDTH), minimum 1 bit.
- busy timing: rises on the accepting edge and falls on the edge leaving DONE.

Test Plan:
- WIDTH=8, a=0x5A, b=0x23, start one cycle:
  - busy rises next cycle; done pulses exactly 9 cycles after the accepting edge.
  - diff=0x37, borrow=0, zero=0.
- a=0x00, b=0x01:
  - diff=0xFF, borrow=1, zero=0.
  - Then a=0xFF, b=0xFF: diff=0x00, borrow=0, zero=1.
- start held high continuously with a=0x10, b=0x01:
  - Results 0x0F with a done pulse every 10 cycles.
  - Changing a/b during RUN does not alter the in-flight result.
  - start in DONE is not accepted.
- Assert rst for one cycle at the 4th RUN cycle of 0x80-0x01:
  - No done pulse; busy=0, diff=0, borrow=0, zero=1 next cycle.
  - A following 0x80-0x01 completes with diff=0x7F, borrow=0.
- Random regression, 1000 operand pairs at WIDTH=8 and at WIDTH=1:
  - diff == (a-b) mod 2^WIDTH and borrow == (a<b) for every done pulse.
  - done is never high for two consecutive cycles.
